// File: rtl/dmem_pkg.sv
// Shared encodings and pipeline stage record for the MEM-stage data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_BAD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_SIZE     = 2'b11
    } err_e;

    // One slot of the read-latency pipeline; word is the raw RAM word read at accept.
    typedef struct packed {
        logic        valid;
        logic        write;
        size_e       size;
        logic        uns;
        logic [1:0]  lane;
        err_e        err;
        logic [31:0] word;
    } stage_t;

    function automatic logic [31:0] sat_inc(logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_dmem_if.sv
// Request/response handshake bundle between the MEM stage and the data memory.
interface pipeline_dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_load_align.sv
// Combinational load extraction: picks the addressed byte/half/word and extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  size_e       size_i,
    input  logic        uns_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word_i >> {lane_i, 3'b000};
        data_o  = '0;
        unique case (size_i)
            SIZE_B:  data_o = {{24{~uns_i & shifted[7]}}, shifted[7:0]};
            SIZE_H:  data_o = {{16{~uns_i & shifted[15]}}, shifted[15:0]};
            SIZE_W:  data_o = word_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/pipeline_dmem.sv
// Parametrised MEM-stage data memory with byte/half/word access and RD_LATENCY pipeline.
// Optional DMEM_STATS_EN adds saturating load/store/error counters.
module pipeline_dmem
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    pipeline_dmem_if.slave     bus
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]        stat_loads_o,
    output logic [31:0]        stat_stores_o,
    output logic [31:0]        stat_errs_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    stage_t        st_q [RD_LATENCY];
    stage_t        last;
    size_e         size;
    err_e          err;
    logic          stall;
    logic          accept;
    logic [31:0]   off;
    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic [31:0]   load_data;

    assign size   = size_e'(bus.req_size);
    assign last   = st_q[RD_LATENCY-1];
    assign stall  = last.valid & ~bus.rsp_ready;
    assign accept = bus.req_valid & bus.req_ready;
    assign off    = bus.req_addr - BASE_ADDR;
    assign lane   = off[1:0];
    assign idx    = off[AW+1:2];

    assign bus.req_ready = ~reset_i & ~stall;

    always_comb begin
        err = ERR_OK;
        if (size == SIZE_BAD) begin
            err = ERR_SIZE;
        end else if ((size == SIZE_H && lane[0]) || (size == SIZE_W && lane != 2'b00)) begin
            err = ERR_MISALIGN;
        end else if ((off >> (AW + 2)) != 32'd0) begin
            err = ERR_RANGE;
        end
    end

    // Replicate store data across lanes so each byte enable picks its own byte.
    always_comb begin
        be        = '0;
        wdata_rep = bus.req_wdata;
        unique case (size)
            SIZE_B: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{bus.req_wdata[7:0]}};
            end
            SIZE_H: begin
                be        = 4'b0011 << lane;
                wdata_rep = {2{bus.req_wdata[15:0]}};
            end
            SIZE_W:  be = 4'b1111;
            default: be = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (accept && bus.req_write && err == ERR_OK) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    // Stage 0 doubles as the synchronous read register; a stall freezes every stage.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < RD_LATENCY; i++) st_q[i].valid <= 1'b0;
        end else if (!stall) begin
            st_q[0] <= '{valid: accept, write: bus.req_write, size: size,
                         uns: bus.req_unsigned, lane: lane, err: err, word: mem[idx]};
            for (int i = 1; i < RD_LATENCY; i++) st_q[i] <= st_q[i-1];
        end
    end

    dmem_load_align u_align (
        .word_i (last.word),
        .lane_i (last.lane),
        .size_i (last.size),
        .uns_i  (last.uns),
        .data_o (load_data)
    );

    assign bus.rsp_valid = last.valid;
    assign bus.rsp_err   = last.valid ? last.err : ERR_OK;
    assign bus.rsp_rdata = (last.valid && !last.write && last.err == ERR_OK) ? load_data : '0;

`ifdef DMEM_STATS_EN
    logic [31:0] loads_q, stores_q, errs_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            loads_q  <= '0;
            stores_q <= '0;
            errs_q   <= '0;
        end else if (accept) begin
            if (err != ERR_OK)      errs_q   <= sat_inc(errs_q);
            else if (bus.req_write) stores_q <= sat_inc(stores_q);
            else                    loads_q  <= sat_inc(loads_q);
        end
    end

    assign stat_loads_o  = loads_q;
    assign stat_stores_o = stores_q;
    assign stat_errs_o   = errs_q;
`endif

endmodule

// File: tb/tb_pipeline_dmem.sv
// Self-checking bench for pipeline_dmem: directed vector table, stall/reset sequences,
// randomized traffic against a byte-array reference model.
module tb_pipeline_dmem;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int unsigned LAT   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_dmem_if bus ();

`ifdef DMEM_STATS_EN
    logic [31:0] st_loads, st_stores, st_errs;
`endif

    pipeline_dmem #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .RD_LATENCY  (LAT)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
`ifdef DMEM_STATS_EN
        ,
        .stat_loads_o  (st_loads),
        .stat_stores_o (st_stores),
        .stat_errs_o   (st_errs)
`endif
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_err;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    exp_t        sb[$];
    logic [7:0]  mem_m [DEPTH*4];
    int          n_loads = 0, n_stores = 0, n_errs = 0;
    int          n_rsp = 0, n_stall = 0;
    logic        acc_seen = 1'b0, rsp_seen = 1'b0;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_e;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // Reference: byte-addressed array, rules computed arithmetically.
    function automatic void model(input logic wr, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic [1:0] err);
        logic [31:0] off, val;
        int nb;
        off = addr - BASE;
        nb  = 1 << sz;
        rd  = '0;
        val = '0;
        if (sz == 2'd3)                    err = 2'd3;
        else if (off % 32'(nb) != 0)       err = 2'd1;
        else if (off >= 32'(DEPTH * 4))    err = 2'd2;
        else                               err = 2'd0;
        if (err != 2'd0)  n_errs++;
        else if (wr)      n_stores++;
        else              n_loads++;
        if (err == 2'd0) begin
            if (wr) begin
                for (int b = 0; b < nb; b++) mem_m[off + 32'(b)] = wd[8*b +: 8];
            end else begin
                for (int b = 0; b < nb; b++) val |= 32'(mem_m[off + 32'(b)]) << (8 * b);
                if (!uns && nb < 4 && val[8*nb-1]) val |= 32'hFFFF_FFFF << (8 * nb);
                rd = val;
            end
        end
    endfunction

    // Evaluates the handshakes for the coming edge, then advances one clock.
    task automatic tick();
        exp_t e;
        #1;
        acc_seen = bus.req_valid && bus.req_ready;
        rsp_seen = bus.rsp_valid && bus.rsp_ready;
        if (reset) begin
            check("ready_in_reset", 32'(bus.req_ready), 32'd0);
            sb.delete();
            acc_seen = 1'b0;
            rsp_seen = 1'b0;
            n_loads  = 0;
            n_stores = 0;
            n_errs   = 0;
        end else begin
            if (bus.rsp_valid && !bus.rsp_ready) begin
                n_stall++;
                check("ready_low_on_stall", 32'(bus.req_ready), 32'd0);
            end
            if (rsp_seen) begin
                rsp_data = bus.rsp_rdata;
                rsp_e    = bus.rsp_err;
                n_rsp++;
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_rdata", bus.rsp_rdata, e.rdata);
                    check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                end
            end
            if (acc_seen) begin
                model(bus.req_write, bus.req_size, bus.req_unsigned, bus.req_addr,
                      bus.req_wdata, e.rdata, e.err);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
        bus.req_valid    = v;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
    endtask

    task automatic stream_op(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd);
        int k = 0;
        set_req(1'b1, wr, sz, uns, addr, wd);
        do begin
            tick();
            k++;
        end while (!acc_seen && k < 20);
        if (!acc_seen) check("accept_timeout", 32'(acc_seen), 32'd1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        while (sb.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic single_op(input vec_t v);
        int lat = 0;
        bus.rsp_ready = 1'b1;
        stream_op(v.wr, v.sz, v.uns, v.addr, v.wdata);
        do begin
            tick();
            lat++;
        end while (!rsp_seen && lat < 20);
        check({v.name, "_latency"}, 32'(lat), 32'(LAT));
        check({v.name, "_rdata"}, rsp_data, v.exp_rdata);
        check({v.name, "_err"}, 32'(rsp_e), 32'(v.exp_err));
    endtask

    vec_t vt[$];

    initial begin
        int issued, rsp0, stall0;
        logic [1:0] rsz;

        vt.push_back('{"sw_10",    1, 2'd2, 0, 32'h10,  32'hDEADBEEF, 32'h0,        2'd0});
        vt.push_back('{"lw_10",    0, 2'd2, 0, 32'h10,  32'h0,        32'hDEADBEEF, 2'd0});
        vt.push_back('{"sb_11",    1, 2'd0, 0, 32'h11,  32'h0000007F, 32'h0,        2'd0});
        vt.push_back('{"lb_11",    0, 2'd0, 0, 32'h11,  32'h0,        32'h0000007F, 2'd0});
        vt.push_back('{"lbu_13",   0, 2'd0, 1, 32'h13,  32'h0,        32'h000000DE, 2'd0});
        vt.push_back('{"lh_12",    0, 2'd1, 0, 32'h12,  32'h0,        32'hFFFFDEAD, 2'd0});
        vt.push_back('{"lhu_12",   0, 2'd1, 1, 32'h12,  32'h0,        32'h0000DEAD, 2'd0});
        vt.push_back('{"lb_10",    0, 2'd0, 0, 32'h10,  32'h0,        32'hFFFFFFEF, 2'd0});
        vt.push_back('{"lw_12",    0, 2'd2, 0, 32'h12,  32'h0,        32'h0,        2'd1});
        vt.push_back('{"sh_11",    1, 2'd1, 0, 32'h11,  32'h00001234, 32'h0,        2'd1});
        vt.push_back('{"lw_10b",   0, 2'd2, 0, 32'h10,  32'h0,        32'hDEAD7FEF, 2'd0});
        vt.push_back('{"bad_sz",   0, 2'd3, 0, 32'h10,  32'h0,        32'h0,        2'd3});
        vt.push_back('{"bad_sz_w", 1, 2'd3, 0, 32'h11,  32'h0,        32'h0,        2'd3});
        vt.push_back('{"lw_range", 0, 2'd2, 0, 32'h400, 32'h0,        32'h0,        2'd2});
        vt.push_back('{"lw_402",   0, 2'd2, 0, 32'h402, 32'h0,        32'h0,        2'd1});
        vt.push_back('{"sw_0",     1, 2'd2, 0, 32'h0,   32'hCAFEF00D, 32'h0,        2'd0});
        vt.push_back('{"sw_range", 1, 2'd2, 0, 32'h400, 32'h11111111, 32'h0,        2'd2});
        vt.push_back('{"lw_0",     0, 2'd2, 0, 32'h0,   32'h0,        32'hCAFEF00D, 2'd0});
        vt.push_back('{"sh_12",    1, 2'd1, 0, 32'h12,  32'h00008001, 32'h0,        2'd0});
        vt.push_back('{"lw_10c",   0, 2'd2, 0, 32'h10,  32'h0,        32'h80017FEF, 2'd0});
        vt.push_back('{"lh_12b",   0, 2'd1, 0, 32'h12,  32'h0,        32'hFFFF8001, 2'd0});
        vt.push_back('{"sb_3ff",   1, 2'd0, 0, 32'h3FF, 32'h00000080, 32'h0,        2'd0});
        vt.push_back('{"lb_3ff",   0, 2'd0, 0, 32'h3FF, 32'h0,        32'hFFFFFF80, 2'd0});
        vt.push_back('{"lbu_3ff",  0, 2'd0, 1, 32'h3FF, 32'h0,        32'h00000080, 2'd0});
        vt.push_back('{"lw_wrap",  0, 2'd2, 0, 32'hFFFFFFFC, 32'h0,   32'h0,        2'd2});

        // Reset state
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        set_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        tick();
        tick();
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        reset = 1'b0;
        tick();

        // Give every word a known value so later loads have defined expectations
        for (int w = 0; w < int'(DEPTH); w++) stream_op(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);
        drain();

        foreach (vt[i]) single_op(vt[i]);

        // Eight back-to-back loads with a three-cycle consumer stall mid-stream
        issued = 0;
        rsp0   = n_rsp;
        stall0 = n_stall;
        for (int c = 0; c < 60 && (issued < 8 || sb.size() > 0); c++) begin
            bus.rsp_ready = !(c >= 4 && c <= 6);
            if (issued < 8) set_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h40 + 32'(4 * issued), 32'h0);
            else bus.req_valid = 1'b0;
            tick();
            if (acc_seen) issued++;
        end
        bus.req_valid = 1'b0;
        check("stall_issued", 32'(issued), 32'd8);
        check("stall_rsp_count", 32'(n_rsp - rsp0), 32'd8);
        check("stall_observed", 32'(n_stall - stall0 >= 3), 32'd1);
        drain();

        // Reset with two loads in flight
        bus.rsp_ready = 1'b0;
        stream_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        stream_op(1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
        reset = 1'b1;
        tick();
        check("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midreset_rsp_rdata", bus.rsp_rdata, 32'd0);
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        check("post_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        stream_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        stream_op(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        stream_op(1'b0, 2'd0, 1'b1, 32'h3FF, 32'h0);
        drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0, 1, 2: rsz = 2'd0;
                3, 4, 5: rsz = 2'd1;
                6, 7, 8: rsz = 2'd2;
                default: rsz = 2'd3;
            endcase
            set_req(($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), rsz,
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 + 7)),
                    $urandom);
            tick();
        end
        drain();

`ifdef DMEM_STATS_EN
        check("stat_loads_run", st_loads, 32'(n_loads));
        check("stat_stores_run", st_stores, 32'(n_stores));
        check("stat_errs_run", st_errs, 32'(n_errs));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("stat_loads_rst", st_loads, 32'd0);
        check("stat_stores_rst", st_stores, 32'd0);
        check("stat_errs_rst", st_errs, 32'd0);
        for (int i = 0; i < 3; i++) stream_op(1'b0, 2'd2, 1'b0, 32'h10 + 32'(4 * i), 32'h0);
        stream_op(1'b1, 2'd2, 1'b0, 32'h80, 32'h12345678);
        stream_op(1'b1, 2'd1, 1'b0, 32'h86, 32'h0000ABCD);
        stream_op(1'b0, 2'd2, 1'b0, 32'h81, 32'h0);
        drain();
        check("stat_loads", st_loads, 32'd3);
        check("stat_stores", st_stores, 32'd2);
        check("stat_errs", st_errs, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("stat_loads_clr", st_loads, 32'd0);
        check("stat_stores_clr", st_stores, 32'd0);
        check("stat_errs_clr", st_errs, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
